// File: rtl/cpu_pkg.sv
// Definitions shared by the accumulator, the ALU and the accumulator output port.
// Holds the datapath word width, the word type and the parity helper.
package cpu_pkg;

   localparam int DATA_W = 8;

   typedef logic [DATA_W-1:0] word_t;

   // Even parity: the returned bit makes the total number of ones even.
   function automatic logic even_parity(input word_t w);
      return ^w;
   endfunction

endpackage

// File: rtl/acc_out_fifo_mem.sv
// Storage array for the accumulator output FIFO.
// It has one synchronous write port and an asynchronous read port. The array has no reset.
module acc_out_fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write port: one entry per cycle while we is high.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/acc_out_port.sv
// Accumulator output port: a small FIFO that drains to a device over valid/ready.
// Defining ACC_OUT_PARITY_EN stores a parity bit with each word and adds the out_parity output.
module acc_out_port
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              CLB,
   input  logic              store,
   input  word_t             acc_in,
   input  logic              clr_err,
   output word_t             out_data,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef ACC_OUT_PARITY_EN
   output logic              out_parity,
`endif
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count,
   output logic              drop_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef ACC_OUT_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             drop_err_q, drop_err_d;
   logic             push_s, pop_s;
   logic [MEM_W-1:0] wdata_s, rdata_s;

   acc_out_fifo_mem #(
      .WIDTH (MEM_W),
      .DEPTH (DEPTH),
      .AW    (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (push_s),
      .waddr (wptr_q),
      .wdata (wdata_s),
      .raddr (rptr_q),
      .rdata (rdata_s)
   );

   // Status is derived only from the registered count, so out_ready never reaches out_valid.
   always_comb begin
      empty     = (count_q == CNT_W'(0));
      full      = (count_q == CNT_W'(DEPTH));
      count     = count_q;
      drop_err  = drop_err_q;
      out_valid = ~empty;
      out_data  = out_valid ? rdata_s[DATA_W-1:0] : word_t'(0);
`ifdef ACC_OUT_PARITY_EN
      out_parity = out_valid ? rdata_s[DATA_W] : 1'b0;
`endif
   end

   // Handshake decode and next state for pointers, occupancy and the sticky drop flag.
   always_comb begin
      pop_s      = out_valid & out_ready;
      push_s     = store & (~full | pop_s);
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      drop_err_d = drop_err_q;
`ifdef ACC_OUT_PARITY_EN
      wdata_s    = {even_parity(acc_in), acc_in};
`else
      wdata_s    = acc_in;
`endif

      if (push_s) begin
         wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wptr_q + PTR_W'(1);
      end else begin
         wptr_d = wptr_q;
      end

      if (pop_s) begin
         rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rptr_q + PTR_W'(1);
      end else begin
         rptr_d = rptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // A refused store outranks a clear arriving in the same cycle.
      if (store & full & ~pop_s) begin
         drop_err_d = 1'b1;
      end else if (clr_err) begin
         drop_err_d = 1'b0;
      end else begin
         drop_err_d = drop_err_q;
      end
   end

   // State registers; a clear empties the queue regardless of any handshake in flight.
   always_ff @(posedge clk or negedge CLB) begin
      if (!CLB) begin
         wptr_q     <= PTR_W'(0);
         rptr_q     <= PTR_W'(0);
         count_q    <= CNT_W'(0);
         drop_err_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         drop_err_q <= drop_err_d;
      end
   end

endmodule

// File: tb/tb_acc_out_port.sv
// Directed self-checking bench for acc_out_port (also covers ACC_OUT_PARITY_EN builds).
module tb_acc_out_port;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       CLB;
   logic       store;
   word_t      acc_in;
   logic       clr_err;
   word_t      out_data;
   logic       out_valid;
   logic       out_ready;
   logic       full;
   logic       empty;
   logic [2:0] count;
   logic       drop_err;
`ifdef ACC_OUT_PARITY_EN
   logic       out_parity;
`endif

   int tests  = 0;
   int failed = 0;

   acc_out_port dut (
      .clk       (clk),
      .CLB       (CLB),
      .store     (store),
      .acc_in    (acc_in),
      .clr_err   (clr_err),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef ACC_OUT_PARITY_EN
      .out_parity(out_parity),
`endif
      .full      (full),
      .empty     (empty),
      .count     (count),
      .drop_err  (drop_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      word_t exp_q[$];
      word_t fill3[4];
      word_t held;
      logic  hold;
      int    sent;
      int    rx;

      // 1. reset with store asserted
      CLB = 1'b0; store = 1'b1; acc_in = 8'h5A; clr_err = 1'b0; out_ready = 1'b0;
      cycle(); cycle();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_drop", 32'(drop_err), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      store = 1'b0;
      #2 CLB = 1'b1;
      cycle();
      chk("rel_valid", 32'(out_valid), 32'd0);
      chk("rel_empty", 32'(empty), 32'd1);
      chk("rel_count", 32'(count), 32'd0);
      chk("rel_drop", 32'(drop_err), 32'd0);

      // 2. single word, one-cycle latency
      out_ready = 1'b1; store = 1'b1; acc_in = 8'hA5;
      cycle();
      store = 1'b0;
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data", 32'(out_data), 32'hA5);
      chk("single_count", 32'(count), 32'd1);
      cycle();
      chk("single_empty", 32'(empty), 32'd1);
      chk("single_valid0", 32'(out_valid), 32'd0);

      // 3. fill under back-pressure, overflow drop, drain, clear
      out_ready = 1'b0;
      fill3[0] = 8'h11; fill3[1] = 8'h22; fill3[2] = 8'h33; fill3[3] = 8'h44;
      for (int k = 0; k < 4; k++) begin
         store = 1'b1; acc_in = fill3[k];
         cycle();
      end
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_nodrop", 32'(drop_err), 32'd0);
      acc_in = 8'h55;
      cycle();
      store = 1'b0;
      chk("ovf_drop", 32'(drop_err), 32'd1);
      chk("ovf_count", 32'(count), 32'd4);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("drain_valid", 32'(out_valid), 32'd1);
         chk("drain_data", 32'(out_data), 32'(fill3[k]));
         cycle();
      end
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drop_sticky", 32'(drop_err), 32'd1);
      clr_err = 1'b1;
      cycle();
      clr_err = 1'b0;
      chk("drop_clr", 32'(drop_err), 32'd0);

      // 4. full with simultaneous push and pop
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         store = 1'b1; acc_in = 8'(k + 1);
         cycle();
      end
      store = 1'b1; acc_in = 8'h66; out_ready = 1'b1;
      chk("fp_head", 32'(out_data), 32'h01);
      cycle();
      store = 1'b0;
      chk("fp_count", 32'(count), 32'd4);
      chk("fp_full", 32'(full), 32'd1);
      chk("fp_nodrop", 32'(drop_err), 32'd0);
      fill3[0] = 8'h02; fill3[1] = 8'h03; fill3[2] = 8'h04; fill3[3] = 8'h66;
      for (int k = 0; k < 4; k++) begin
         chk("fp_data", 32'(out_data), 32'(fill3[k]));
         cycle();
      end
      chk("fp_empty", 32'(empty), 32'd1);

      // 5. streaming with toggling ready, pointer wrap, data stability
      sent = 0; rx = 0; hold = 1'b0; held = 8'h00;
      for (int i = 0; i < 60; i++) begin
         out_ready = (i % 2) == 1;
         store = (sent < 10) && !full;
         acc_in = 8'(8'hB0 + sent);
         if (hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(held));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("stream_extra", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               chk("stream_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            rx++;
         end
         hold = out_valid && !out_ready;
         held = out_data;
         if (store) begin
            exp_q.push_back(acc_in);
            sent++;
         end
         cycle();
      end
      store = 1'b0; out_ready = 1'b1;
      cycle();
      chk("stream_rx", 32'(rx), 32'd10);
      chk("stream_empty", 32'(empty), 32'd1);

      // 6. clear in mid-operation discards queued words
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         store = 1'b1; acc_in = 8'(8'hC1 + k);
         cycle();
      end
      store = 1'b0;
      chk("mid_count3", 32'(count), 32'd3);
      #2 CLB = 1'b0;
      #1;
      chk("mid_count0", 32'(count), 32'd0);
      chk("mid_valid0", 32'(out_valid), 32'd0);
      chk("mid_empty", 32'(empty), 32'd1);
      #2 CLB = 1'b1;
      cycle();
      store = 1'b1; acc_in = 8'h77;
      cycle();
      store = 1'b0;
      chk("post_valid", 32'(out_valid), 32'd1);
      chk("post_data", 32'(out_data), 32'h77);
      chk("post_count", 32'(count), 32'd1);
`ifdef ACC_OUT_PARITY_EN
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0; store = 1'b1; acc_in = 8'h07;
      cycle();
      store = 1'b0;
      chk("par_data07", 32'(out_data), 32'h07);
      chk("par_07", 32'(out_parity), 32'd1);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0; store = 1'b1; acc_in = 8'h03;
      cycle();
      store = 1'b0;
      chk("par_data03", 32'(out_data), 32'h03);
      chk("par_03", 32'(out_parity), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
